// File: rtl/fpga_reset_sequencer.sv
// Board reset sequencer: syncs/debounces board inputs, gates SoC reset on lock/calib, stretches it, latches boot mode, records cause.
// Latency: async inputs take 2 sync cycles plus 1 state cycle; soc_rst_no changes in the same cycle as state_o.
// Backpressure: none; a held vio_reset_i parks the FSM in HOLD, a held button never retriggers.
module fpga_reset_sequencer #(
  parameter int DebounceCycles = 50000,
  parameter int HoldCycles     = 16,
  parameter bit UseDram        = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       button_i,
  input  logic       vio_reset_i,
  input  logic       mmcm_locked_i,
  input  logic       dram_calib_i,
  input  logic [1:0] boot_mode_i,
  output logic       soc_rst_no,
  output logic [1:0] boot_mode_o,
  output logic [1:0] rst_cause_o,
  output logic [2:0] state_o
);

  localparam int DbW   = $clog2(DebounceCycles + 1);
  localparam int HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [DbW-1:0]   DbMax    = DbW'(DebounceCycles);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

  localparam logic [1:0] CauseBtn  = 2'd1;
  localparam logic [1:0] CauseVio  = 2'd2;
  localparam logic [1:0] CauseLock = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CLK = 3'd1,
    WAIT_MEM = 3'd2,
    HOLD     = 3'd3,
    RUN      = 3'd4
  } state_e;

  state_e           state_q, state_n;
  logic [1:0]       btn_sync, lock_sync, calib_sync;
  logic             btn_s, locked_s, calib_s;
  logic             btn_db;
  logic [DbW-1:0]   db_cnt;
  logic             btn_req;
  logic [HoldW-1:0] hold_cnt;
  logic             hold_restart;
  logic [1:0]       cause_n;

  assign btn_s    = btn_sync[1];
  assign locked_s = lock_sync[1];
  assign calib_s  = calib_sync[1];
  assign state_o  = state_q;

  // A request is the single cycle in which the debounced level is about to rise.
  assign btn_req = btn_s && !btn_db && (db_cnt == DbMax);

  // Two-flop synchronisers for the asynchronous board signals.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_sync   <= '0;
      lock_sync  <= '0;
      calib_sync <= '0;
    end else begin
      btn_sync   <= {btn_sync[0], button_i};
      lock_sync  <= {lock_sync[0], mmcm_locked_i};
      calib_sync <= {calib_sync[0], dram_calib_i};
    end
  end

  // Debounce: count while the synced button disagrees with the debounced level; any agreement restarts the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DbMax) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Next-state, hold-restart and cause selection; requests are prioritised lock > vio > button.
  always_comb begin
    state_n      = state_q;
    hold_restart = 1'b0;
    cause_n      = rst_cause_o;
    case (state_q)
      IDLE: state_n = WAIT_CLK;
      WAIT_CLK: begin
        if (locked_s) state_n = UseDram ? WAIT_MEM : HOLD;
      end
      WAIT_MEM: begin
        if (!locked_s)    state_n = WAIT_CLK;
        else if (calib_s) state_n = HOLD;
      end
      HOLD: begin
        if (!locked_s) begin
          state_n = WAIT_CLK;
        end else if (vio_reset_i || btn_req) begin
          hold_restart = 1'b1;
          cause_n      = vio_reset_i ? CauseVio : CauseBtn;
        end else if (hold_cnt == HoldLast) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_n = WAIT_CLK;
          cause_n = CauseLock;
        end else if (vio_reset_i) begin
          state_n = HOLD;
          cause_n = CauseVio;
        end else if (btn_req) begin
          state_n = HOLD;
          cause_n = CauseBtn;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, hold counter and registered outputs; soc_rst_no follows next-state so it moves with state_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      hold_cnt    <= '0;
      soc_rst_no  <= 1'b0;
      boot_mode_o <= 2'b00;
      rst_cause_o <= 2'b00;
    end else begin
      state_q     <= state_n;
      rst_cause_o <= cause_n;
      soc_rst_no  <= (state_n == RUN);
      if (state_q == HOLD && state_n == HOLD && !hold_restart) hold_cnt <= hold_cnt + 1'b1;
      else                                                    hold_cnt <= '0;
      if (state_q == HOLD && state_n == RUN) boot_mode_o <= boot_mode_i;
    end
  end

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Directed bench for fpga_reset_sequencer with DebounceCycles=8, HoldCycles=4, UseDram=1.
// Inputs are driven and outputs sampled on the falling edge; cyc counts rising edges.
// Expected values are hand-computed from sync (2), debounce (8) and hold (4) cycle counts.
module tb_fpga_reset_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       button_i;
  logic       vio_reset_i;
  logic       mmcm_locked_i;
  logic       dram_calib_i;
  logic [1:0] boot_mode_i;
  logic       soc_rst_no;
  logic [1:0] boot_mode_o;
  logic [1:0] rst_cause_o;
  logic [2:0] state_o;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int la, lb;

  fpga_reset_sequencer #(
    .DebounceCycles(8),
    .HoldCycles(4),
    .UseDram(1'b1)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .button_i(button_i),
    .vio_reset_i(vio_reset_i),
    .mmcm_locked_i(mmcm_locked_i),
    .dram_calib_i(dram_calib_i),
    .boot_mode_i(boot_mode_i),
    .soc_rst_no(soc_rst_no),
    .boot_mode_o(boot_mode_o),
    .rst_cause_o(rst_cause_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk_i);
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (soc_rst_no == 1'b0) lows++;
    end
  endtask

  initial begin
    rst_i = 1'b1; button_i = 1'b0; vio_reset_i = 1'b0;
    mmcm_locked_i = 1'b0; dram_calib_i = 1'b0; boot_mode_i = 2'b01;

    // 1. POR, then lock at cycle 10 and calibration at cycle 20
    goto(2);
    chk("por_soc_rst", soc_rst_no, 0);
    chk("por_state", state_o, 0);
    chk("por_cause", rst_cause_o, 0);
    chk("por_boot", boot_mode_o, 0);
    goto(3); rst_i = 1'b0;
    goto(4);  chk("idle_to_waitclk", state_o, 1);
    goto(10); mmcm_locked_i = 1'b1;
    goto(12); chk("still_waitclk", state_o, 1);
    goto(13); chk("waitmem", state_o, 2);
    goto(20); dram_calib_i = 1'b1;
    goto(22); chk("waitmem_before_calib", state_o, 2);
    goto(23); chk("hold_at_c3", state_o, 3);
    goto(26); chk("soc_low_c6", soc_rst_no, 0);
    goto(27);
    chk("soc_high_c7", soc_rst_no, 1);
    chk("run_c7", state_o, 4);
    chk("cause_por", rst_cause_o, 0);
    chk("boot_first", boot_mode_o, 1);

    // 2. Short pulse is filtered; a long press gives exactly one 4-cycle reset
    tick(3);
    button_i = 1'b1; count_low(5, la);
    button_i = 1'b0; count_low(20, lb);
    chk("short_pulse_lows", la + lb, 0);
    button_i = 1'b1; count_low(20, la);
    button_i = 1'b0; count_low(20, lb);
    chk("press_lows", la, 4);
    chk("release_lows", lb, 0);
    chk("press_cause", rst_cause_o, 1);
    chk("press_run", state_o, 4);

    // 3. Lock loss in RUN, then relock
    mmcm_locked_i = 1'b0;
    tick(3);
    chk("lockloss_soc", soc_rst_no, 0);
    chk("lockloss_state", state_o, 1);
    chk("lockloss_cause", rst_cause_o, 3);
    mmcm_locked_i = 1'b1;
    tick(3); chk("relock_waitmem", state_o, 2);
    tick(1); chk("relock_hold", state_o, 3);
    tick(3); chk("relock_soc_low", soc_rst_no, 0);
    tick(1);
    chk("relock_soc_high", soc_rst_no, 1);
    chk("relock_cause", rst_cause_o, 3);

    // 4a. vio and debounced button edge in the same cycle: vio wins
    tick(2);
    button_i = 1'b1;
    tick(10); vio_reset_i = 1'b1;
    tick(1);  vio_reset_i = 1'b0;
    chk("simul_state", state_o, 3);
    chk("simul_cause", rst_cause_o, 2);
    tick(4);  chk("simul_run", soc_rst_no, 1);
    button_i = 1'b0;
    tick(15);

    // 4b. Button edge during HOLD restarts the hold: low time 1 + 1 + 4 = 6
    button_i = 1'b1;
    tick(8); vio_reset_i = 1'b1;
    count_low(1, la);
    vio_reset_i = 1'b0;
    count_low(15, lb);
    chk("hold_extend_lows", la + lb, 6);
    chk("hold_extend_cause", rst_cause_o, 1);
    button_i = 1'b0;
    tick(15);

    // 5. Boot mode is latched only on RUN entry
    boot_mode_i = 2'b10;
    tick(5); chk("boot_stays", boot_mode_o, 1);
    vio_reset_i = 1'b1;
    tick(1); vio_reset_i = 1'b0;
    tick(3);
    chk("boot_in_hold", boot_mode_o, 1);
    chk("vio_hold", state_o, 3);
    tick(1);
    chk("boot_new", boot_mode_o, 2);
    chk("vio_run", state_o, 4);
    chk("vio_cause", rst_cause_o, 2);

    // 6. Async reset mid-HOLD, then full restart
    tick(2);
    vio_reset_i = 1'b1;
    tick(1); vio_reset_i = 1'b0;
    tick(1);
    rst_i = 1'b1;
    #1;
    chk("async_soc", soc_rst_no, 0);
    chk("async_state", state_o, 0);
    chk("async_cause", rst_cause_o, 0);
    chk("async_boot", boot_mode_o, 0);
    tick(1); rst_i = 1'b0;
    tick(1); chk("restart_waitclk", state_o, 1);
    tick(1); chk("restart_waitclk2", state_o, 1);
    tick(1); chk("restart_waitmem", state_o, 2);
    tick(1); chk("restart_hold", state_o, 3);
    tick(3); chk("restart_soc_low", soc_rst_no, 0);
    tick(1);
    chk("restart_soc_high", soc_rst_no, 1);
    chk("restart_cause", rst_cause_o, 0);
    chk("restart_boot", boot_mode_o, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
